mfc_serial: RTL and testbench
=============================

Name: mfc_serial

Overview:
Bit-serial multi-function comparator. It is the sequential, handshaked counterpart of the parallel 16-bit comparator family, and produces the same result bundle (eq, ae, gt, d). On a start request it latches operands A and B, then scans one bit per clock from MSB to LSB. When the scan finishes it presents registered results with a one-cycle done pulse. It sits behind the operand-issue logic wherever area matters more than latency.

Parameters:
WIDTH, 16, operand width in bits (must be a power of two, at least 2)
DW, 4, width of d; equals clog2(WIDTH)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A; sampled on the accepting edge only
b  input  WIDTH  operand B; sampled on the accepting edge only
busy  output  1  high whenever state is not IDLE
done  output  1  one-cycle pulse; results valid from this cycle onward
eq  output  1  A == B
ae  output  1  almost-equal: Hamming distance of A and B is at most 1
gt  output  1  A > B, unsigned
d  output  DW  index of the most-significant differing bit; 0 when A == B

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, rst.
- Reset, asserted at any time including mid-scan:
  - Immediately forces the state to IDLE.
  - Drives busy=0, done=0, eq=0, ae=0, gt=0, d=0.
  - Clears all internal registers; an in-flight operation is discarded.
- States: IDLE, SCAN, DONE.
- IDLE:
  - If start=1 at a rising edge, latch a and b into opA/opB.
  - Set idx=WIDTH-1, hd=0 (2-bit, saturating at 2), found=0, and go to SCAN.
  - If start=0, stay in IDLE.
- SCAN, once per cycle on bit idx:
  - Let diff = opA[idx] ^ opB[idx].
  - If diff=1, increment hd, saturating at 2.
  - If diff=1 and found=0, set found=1, dreg=idx, gtreg=opA[idx].
  - If idx=0, go to DONE on this edge and load the outputs from the final values of that step:
    - eq = ~found
    - ae = (hd <= 1)
    - gt = gtreg
    - d = found ? dreg : 0
  - Otherwise decrement idx.
  - There is no early termination: all WIDTH bits are always scanned, because ae needs the full Hamming count.
- DONE:
  - done=1 for exactly this one cycle; the next state is IDLE unconditionally.
  - start is ignored in DONE.
- Result holding: eq, ae, gt and d hold their values until the next operation reaches DONE. They are not cleared on start.
- Latency: if start is accepted on edge 0, the state is SCAN for cycles 1..WIDTH, DONE (done=1) at cycle WIDTH+1, and IDLE at WIDTH+2.
  - With start held high, operations run back to back with a period of WIDTH+2 cycles (18 for the default).
- Protocol rules:
  - start while busy=1 is ignored; it is not queued.
  - Changing a or b while busy=1 has no effect on the current result.
- Widths: idx is DW bits. The idx=0 test must not depend on a decrement underflowing.

Decomposition:
- Package mfc_pkg:
  - WIDTH default and DW constant.
  - State enum: IDLE, SCAN, DONE.
  - Packed struct mfc_result_t {eq, ae, gt, d}, shared with the parallel comparators.
- Sub-module mfc_scan_step, combinational:
  - Inputs: bitA, bitB, idx, hd, found, dreg, gtreg.
  - Outputs: the next values of hd, found, dreg and gtreg.
  - The FSM/counter top instantiates it once.

Test Plan:
1. A=0xD3DB, B=0xD3DB, start pulse -> done at cycle 17 after acceptance; eq=1, ae=1, gt=0, d=0; busy high for cycles 1..17.
2. A=0x53DB, B=0xD3DB -> eq=0, ae=1, gt=0, d=15 (MSB boundary, single differing bit).
3. A=0x0003, B=0x0000 -> eq=0, ae=0, gt=1, d=1; A=0x0001, B=0x0000 -> ae=1, gt=1, d=0 (LSB boundary).
4. A=0x8000, B=0x7FFF -> eq=0, ae=0 (hd saturates at 2), gt=1, d=15.
5. Start accepted with A=0xFFFF, B=0x0000. A second start with new operands at cycle 5 is ignored; results are gt=1, d=15. At cycle 8 of a later operation rst=1 -> busy=0 and all outputs 0 without waiting for an edge. A new start after release completes correctly.
6. start held high with operands alternating per accept -> done pulses exactly every 18 cycles, each carrying its own operands' results; previous results stay stable between pulses.

Source files
------------

// File: rtl/mfc_pkg.sv
// Shared definitions for the mfc comparator family: operand width, state
// encoding and the result bundle common to serial and parallel variants.
package mfc_pkg;
  localparam int WIDTH = 16;
  localparam int DW    = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } mfc_state_e;

  typedef struct packed {
    logic          eq;
    logic          ae;
    logic          gt;
    logic [DW-1:0] d;
  } mfc_result_t;
endpackage

// File: rtl/mfc_serial_if.sv
// Handshake and result bus between the operand-issue logic and mfc_serial.
interface mfc_serial_if #(
  parameter int WIDTH = 16,
  parameter int DW    = $clog2(WIDTH)
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             eq;
  logic             ae;
  logic             gt;
  logic [DW-1:0]    d;

  modport master (output start, a, b, input busy, done, eq, ae, gt, d);
  modport slave  (input start, a, b, output busy, done, eq, ae, gt, d);
endinterface

// File: rtl/mfc_scan_step.sv
// One bit of the MSB-first scan: updates the saturating Hamming count and
// captures position/direction of the first (most significant) difference.
module mfc_scan_step #(
  parameter int DW = 4
) (
  input  logic          bita,
  input  logic          bitb,
  input  logic [DW-1:0] idx,
  input  logic [1:0]    hd,
  input  logic          found,
  input  logic [DW-1:0] dreg,
  input  logic          gtreg,
  output logic [1:0]    hd_n,
  output logic          found_n,
  output logic [DW-1:0] dreg_n,
  output logic          gtreg_n
);
  logic diff, first;

  assign diff    = bita ^ bitb;
  assign first   = diff & ~found;
  // hd only needs to distinguish 0, 1 and "2 or more"
  assign hd_n    = (diff && hd != 2'd2) ? hd + 2'd1 : hd;
  assign found_n = found | diff;
  assign dreg_n  = first ? idx : dreg;
  assign gtreg_n = first ? bita : gtreg;
endmodule

// File: rtl/mfc_serial.sv
// Bit-serial comparator: latches A/B on start, scans MSB->LSB one bit per
// clock, then presents eq/ae/gt/d with a one-cycle done pulse.
module mfc_serial #(
  parameter int WIDTH = mfc_pkg::WIDTH,
  parameter int DW    = $clog2(WIDTH)
) (
  input  logic         clk,
  input  logic         rst,
  mfc_serial_if.slave  bus
);
  import mfc_pkg::*;

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_SCAN = SCAN;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]       state;
  logic [WIDTH-1:0] opa, opb;
  logic [DW-1:0]    idx, dreg, dreg_n, d_r;
  logic [1:0]       hd, hd_n;
  logic             found, found_n, gtreg, gtreg_n;
  logic             eq_r, ae_r, gt_r;

  mfc_scan_step #(.DW(DW)) u_step (
    .bita    (opa[idx]),
    .bitb    (opb[idx]),
    .idx     (idx),
    .hd      (hd),
    .found   (found),
    .dreg    (dreg),
    .gtreg   (gtreg),
    .hd_n    (hd_n),
    .found_n (found_n),
    .dreg_n  (dreg_n),
    .gtreg_n (gtreg_n)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      opa   <= '0;
      opb   <= '0;
      idx   <= '0;
      hd    <= '0;
      found <= 1'b0;
      dreg  <= '0;
      gtreg <= 1'b0;
      eq_r  <= 1'b0;
      ae_r  <= 1'b0;
      gt_r  <= 1'b0;
      d_r   <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          opa   <= bus.a;
          opb   <= bus.b;
          idx   <= DW'(WIDTH - 1);
          hd    <= '0;
          found <= 1'b0;
          dreg  <= '0;
          gtreg <= 1'b0;
          state <= S_SCAN;
        end
        S_SCAN: begin
          hd    <= hd_n;
          found <= found_n;
          dreg  <= dreg_n;
          gtreg <= gtreg_n;
          // always scan every bit: ae needs the full Hamming count
          if (idx == '0) begin
            eq_r  <= ~found_n;
            ae_r  <= (hd_n < 2'd2);
            gt_r  <= gtreg_n;
            d_r   <= found_n ? dreg_n : '0;
            state <= S_DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = (state != S_IDLE);
  assign bus.done = (state == S_DONE);
  assign bus.eq   = eq_r;
  assign bus.ae   = ae_r;
  assign bus.gt   = gt_r;
  assign bus.d    = d_r;
endmodule

// File: tb/tb_mfc_serial.sv
// Self-checking bench for mfc_serial: vector table, scoreboard queue and
// hand-written sequences for busy-start, mid-scan reset and back-to-back runs.
module tb_mfc_serial;
  import mfc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mfc_serial_if #(.WIDTH(WIDTH), .DW(DW)) bus ();
  mfc_serial #(.WIDTH(WIDTH), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mfc_result_t sbq[$];

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    mfc_result_t      exp;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                              logic eq, logic ae, logic gt, int d);
    vec_t v;
    v.a = a; v.b = b;
    v.exp.eq = eq; v.exp.ae = ae; v.exp.gt = gt; v.exp.d = DW'(d);
    return v;
  endfunction

  // Independent reference: direct compare, popcount and LSB->MSB search
  function automatic mfc_result_t model(logic [WIDTH-1:0] x, logic [WIDTH-1:0] y);
    mfc_result_t r;
    logic [WIDTH-1:0] df;
    df = x ^ y;
    r = '0;
    r.eq = (df == '0);
    r.ae = ($countones(df) <= 1);
    r.gt = (x > y);
    for (int i = 0; i < WIDTH; i++) if (df[i]) r.d = DW'(i);
    return r;
  endfunction

  function automatic mfc_result_t dut_res();
    mfc_result_t r;
    r.eq = bus.eq; r.ae = bus.ae; r.gt = bus.gt; r.d = bus.d;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pop_check(input string name);
    mfc_result_t e;
    if (sbq.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s: done with empty scoreboard", name);
    end else begin
      e = sbq.pop_front();
      check(name, 32'(dut_res()), 32'(e));
    end
  endtask

  // Counts negedges until done; tracks busy and whether outputs held 'hold'.
  task automatic wait_done(input int limit, input mfc_result_t hold,
                           output int n, output bit busy_ok, output bit hold_ok);
    bit ok;
    n = 0; ok = 0; busy_ok = 1; hold_ok = 1;
    while (n < limit && !ok) begin
      @(negedge clk);
      n++;
      if (!bus.busy) busy_ok = 0;
      if (bus.done) ok = 1;
      else if (dut_res() !== hold) hold_ok = 0;
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles", limit);
    end
  endtask

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input mfc_result_t exp);
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b;
    sbq.push_back(exp);
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  initial begin
    int n, last_done;
    bit busy_ok, hold_ok;
    mfc_result_t prev, p0, p1;

    vecs[0] = mk(16'hD3DB, 16'hD3DB, 1, 1, 0, 0);
    vecs[1] = mk(16'h53DB, 16'hD3DB, 0, 1, 0, 15);
    vecs[2] = mk(16'h0003, 16'h0000, 0, 0, 1, 1);
    vecs[3] = mk(16'h0001, 16'h0000, 0, 1, 1, 0);
    vecs[4] = mk(16'h8000, 16'h7FFF, 0, 0, 1, 15);
    vecs[5] = mk(16'h0000, 16'h0001, 0, 1, 0, 0);
    vecs[6] = mk(16'hFFFF, 16'hFFFE, 0, 1, 1, 0);
    vecs[7] = mk(16'h00F0, 16'h0F00, 0, 0, 0, 11);

    rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {bus.busy, bus.done, bus.eq, bus.ae, bus.gt, 28'(bus.d)}, 32'h0);
    rst = 1'b0;

    // table vectors: result, latency (done in cycle WIDTH+1), busy window
    prev = '0;
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].exp);
      wait_done(40, prev, n, busy_ok, hold_ok);
      pop_check($sformatf("vec%0d_result", i));
      check($sformatf("vec%0d_latency", i), n, WIDTH + 1);
      check($sformatf("vec%0d_busy", i), busy_ok, 1);
      check($sformatf("vec%0d_hold", i), hold_ok, 1);
      prev = vecs[i].exp;
      if (i == 0) begin
        @(negedge clk);
        check("idle_after_done", {bus.busy, bus.done}, 0);
      end
    end

    // start while busy is ignored; operand changes do not disturb the scan
    issue(16'hFFFF, 16'h0000, model(16'hFFFF, 16'h0000));
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h0000; bus.b = 16'hFFFF;
    @(negedge clk);
    bus.start = 1'b0; bus.a = 16'h1234; bus.b = 16'h4321;
    wait_done(40, prev, n, busy_ok, hold_ok);
    pop_check("busy_start_result");
    check("busy_start_latency", n, WIDTH + 1 - 5);
    @(negedge clk);
    @(negedge clk);
    check("busy_start_not_queued", bus.busy, 0);

    // asynchronous reset mid-scan clears outputs before any edge
    issue(16'h1234, 16'h1234, model(16'h1234, 16'h1234));
    repeat (7) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset_outputs",
             {bus.busy, bus.done, bus.eq, bus.ae, bus.gt, 28'(bus.d)}, 32'h0);
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    issue(16'h00F0, 16'h0F00, model(16'h00F0, 16'h0F00));
    wait_done(40, '0, n, busy_ok, hold_ok);
    pop_check("post_reset_result");
    check("post_reset_hold", hold_ok, 1);

    // start held high, operands alternating per accept
    prev = model(16'h00F0, 16'h0F00);
    p0 = model(16'h8000, 16'h7FFF);
    p1 = model(16'h0001, 16'h0000);
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h8000; bus.b = 16'h7FFF;
    sbq.push_back(p0);
    last_done = 0;
    for (int k = 0; k < 4; k++) begin
      wait_done(40, prev, n, busy_ok, hold_ok);
      pop_check($sformatf("b2b%0d_result", k));
      check($sformatf("b2b%0d_hold", k), hold_ok, 1);
      if (k > 0) check($sformatf("b2b%0d_period", k), cyc - last_done, WIDTH + 2);
      last_done = cyc;
      prev = (k % 2 == 0) ? p0 : p1;
      if (k < 3) begin
        if (k % 2 == 0) begin bus.a = 16'h0001; bus.b = 16'h0000; sbq.push_back(p1); end
        else            begin bus.a = 16'h8000; bus.b = 16'h7FFF; sbq.push_back(p0); end
      end else begin
        bus.start = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    check("final_idle", bus.busy, 0);
    check("scoreboard_empty", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
